// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: extraction modes, field
// widths and the output-buffer occupancy states. The control unit imports
// the same mode encodings.
package imm_pkg;

  // Extraction modes driven by the decoder; 5..7 are reserved.
  localparam logic [2:0] IMM_ALU  = 3'd0;
  localparam logic [2:0] IMM_BR   = 3'd1;
  localparam logic [2:0] IMM_CB   = 3'd2;
  localparam logic [2:0] IMM_DT   = 3'd3;
  localparam logic [2:0] IMM_MOVZ = 3'd4;

  // Raw field widths before extension.
  localparam int ALU_W  = 12;
  localparam int BR_W   = 26;
  localparam int CB_W   = 19;
  localparam int DT_W   = 9;
  localparam int MOVZ_W = 16;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: selects the field for the given mode,
// zero- or sign-extends it to DATA_W and applies the mode's shift.
module imm_extract
  import imm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter bit SHIFT_BR = 1'b1
) (
  input  logic [25:0]       ins,
  input  logic [2:0]        mode,
  output logic [DATA_W-1:0] imm,
  output logic              err
);

  logic [DATA_W-1:0] alu_ext;
  logic [DATA_W-1:0] br_sext;
  logic [DATA_W-1:0] cb_sext;
  logic [DATA_W-1:0] dt_ext;
  logic [DATA_W-1:0] movz_zext;
  logic [DATA_W-1:0] br_ext;
  logic [DATA_W-1:0] cb_ext;
  logic [DATA_W-1:0] movz_ext;
  logic [5:0]        movz_sh;

  // Extended fields; sign extension replicates each field's MSB.
  assign alu_ext   = {{(DATA_W-ALU_W){1'b0}}, ins[21:10]};
  assign br_sext   = {{(DATA_W-BR_W){ins[25]}}, ins[25:0]};
  assign cb_sext   = {{(DATA_W-CB_W){ins[23]}}, ins[23:5]};
  assign dt_ext    = {{(DATA_W-DT_W){ins[20]}}, ins[20:12]};
  assign movz_zext = {{(DATA_W-MOVZ_W){1'b0}}, ins[20:5]};

  // Branch offsets count words; shifting turns them into byte offsets.
  // Bits pushed above DATA_W-1 are simply lost.
  assign br_ext   = SHIFT_BR ? (br_sext << 2) : br_sext;
  assign cb_ext   = SHIFT_BR ? (cb_sext << 2) : cb_sext;
  assign movz_sh  = {ins[22:21], 4'b0000};
  assign movz_ext = movz_zext << movz_sh;

  // Mode select; reserved modes and out-of-range MOVZ halfwords flag err.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    imm = '0;
    err = 1'b0;
    case (mode)
      IMM_ALU: imm = alu_ext;
      IMM_BR:  imm = br_ext;
      IMM_CB:  imm = cb_ext;
      IMM_DT:  imm = dt_ext;
      IMM_MOVZ: begin
        if (DATA_W == 32 && ins[22]) begin
          err = 1'b1;
        end else begin
          imm = movz_ext;
        end
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: combinational extraction feeding a 2-entry
// valid/ready buffer so decode and execute can stall independently.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter bit SHIFT_BR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       ins,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic              err
);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic              err;
  } entry_t;

  fifo_state_e       state_q;
  fifo_state_e       state_d;
  entry_t            mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              head_sel;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] x_imm;
  logic              x_err;

  imm_extract #(
    .DATA_W   (DATA_W),
    .SHIFT_BR (SHIFT_BR)
  ) u_extract (
    .ins  (ins),
    .mode (mode),
    .imm  (x_imm),
    .err  (x_err)
  );

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs decoded from the registered occupancy only; a full
  // buffer refuses input even while it is being popped (no bypass).
  always_comb begin
    in_ready  = !reset && (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  // Entry storage and pointers; the entry is written at the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: storage is cleared on reset because imm must read 0 right after
      // reset and no stale entry may ever reappear.
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{imm: x_imm, err: x_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // When empty, present the slot popped last so imm/err hold their value.
  assign head_sel = out_valid ? rd_ptr : ~rd_ptr;
  assign imm      = mem[head_sel].imm;
  assign err      = mem[head_sel].err;

endmodule
